procesador_harvard: RTL and testbench



---
 rtl/procesador_harvard_pkg.sv | 47 ++++
 rtl/procesador_harvard_if.sv | 23 ++
 rtl/procesador_harvard_alu_acc.sv | 33 +++
 rtl/procesador_harvard.sv | 100 ++++++++++
 tb/tb_procesador_harvard.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/procesador_harvard_pkg.sv
// Shared types and sizing constants for the accumulator Harvard core.
// Opcode values are the architectural encoding seen by the host loader.
package procesador_pkg;

  localparam int INSTR_W    = 37;
  localparam int DATA_W     = 32;
  localparam int OP_W       = 5;
  localparam int IMEM_DEPTH = 128;
  localparam int DMEM_DEPTH = 64;
  localparam int IMEM_AW    = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW    = $clog2(DMEM_DEPTH);

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 5'd0,
    OP_MOVI   = 5'd1,
    OP_SHL    = 5'd2,
    OP_SHR    = 5'd3,
    OP_ADDI   = 5'd4,
    OP_SUBI   = 5'd5,
    OP_MULI   = 5'd6,
    OP_DIVI   = 5'd7,
    OP_ANDI   = 5'd8,
    OP_ORI    = 5'd9,
    OP_XORI   = 5'd10,
    OP_INC    = 5'd11,
    OP_DEC    = 5'd12,
    OP_NOT    = 5'd13,
    OP_BITSET = 5'd14,
    OP_BITCLR = 5'd15,
    OP_LOAD   = 5'd16,
    OP_STORE  = 5'd17,
    OP_ADD    = 5'd18,
    OP_SUB    = 5'd19,
    OP_MUL    = 5'd20,
    OP_DIV    = 5'd21,
    OP_AND    = 5'd22,
    OP_OR     = 5'd23,
    OP_XOR    = 5'd24,
    OP_HALT   = 5'd31
  } opcode_e;

  // Opcodes whose ALU operand is the data-memory word instead of the immediate.
  function automatic logic uses_mem_operand(input logic [OP_W-1:0] op);
    return (op >= OP_LOAD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/procesador_harvard_if.sv
// Host-side bus of the core: program-load port plus observation outputs.
interface procesador_harvard_if;
  import procesador_pkg::*;

  logic               wr;
  logic [IMEM_AW-1:0] address;
  logic [INSTR_W-1:0] data_in;
  logic [DATA_W-1:0]  data_out;
  logic [IMEM_AW-1:0] pc_debug;
  logic [DATA_W-1:0]  rc_debug;
  logic [OP_W-1:0]    op_code_debug;

  modport master (
    output wr, address, data_in,
    input  data_out, pc_debug, rc_debug, op_code_debug
  );

  modport slave (
    input  wr, address, data_in,
    output data_out, pc_debug, rc_debug, op_code_debug
  );

endinterface

// File: rtl/procesador_harvard_alu_acc.sv
// Combinational accumulator ALU: next ACC from opcode, ACC and operand.
// Opcodes that do not change ACC (NOP, STORE, BITSET/BITCLR, HALT) pass ACC through.
module alu_acc
  import procesador_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] acc_next
);

  always_comb begin
    acc_next = acc;
    case (opcode)
      OP_MOVI, OP_LOAD:  acc_next = operand;
      // Any shift amount with bit 5 set is 32 or more and clears ACC.
      OP_SHL:            acc_next = operand[5] ? '0 : (acc << operand[4:0]);
      OP_SHR:            acc_next = operand[5] ? '0 : (acc >> operand[4:0]);
      OP_ADDI, OP_ADD:   acc_next = acc + operand;
      OP_SUBI, OP_SUB:   acc_next = acc - operand;
      OP_MULI, OP_MUL:   acc_next = acc * operand;
      OP_DIVI, OP_DIV:   acc_next = (operand == '0) ? '1 : (acc / operand);
      OP_ANDI, OP_AND:   acc_next = acc & operand;
      OP_ORI,  OP_OR:    acc_next = acc | operand;
      OP_XORI, OP_XOR:   acc_next = acc ^ operand;
      OP_INC:            acc_next = acc + 32'd1;
      OP_DEC:            acc_next = acc - 32'd1;
      OP_NOT:            acc_next = ~acc;
      default:           acc_next = acc;
    endcase
  end

endmodule

// File: rtl/procesador_harvard.sv
// Single-cycle accumulator core: fetch imem[PC], execute and write back on one edge.
// wr=1 turns the core into a program loader and parks PC at 0.
module procesador_harvard
  import procesador_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  procesador_harvard_if.slave  bus
);

  logic [INSTR_W-1:0] imem_q [IMEM_DEPTH];
  logic [DATA_W-1:0]  dmem_q [DMEM_DEPTH];

  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [OP_W-1:0]    op_q, op_d;

  logic [INSTR_W-1:0] instr;
  logic [OP_W-1:0]    instr_op;
  logic [DATA_W-1:0]  instr_imm;
  logic [DMEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0]  mem_operand;
  logic [DATA_W-1:0]  alu_operand;
  logic [DATA_W-1:0]  alu_result;
  logic [4:0]         bit_sel;

  logic               imem_we;
  logic               dmem_we;
  logic [DATA_W-1:0]  dmem_wdata;

  assign instr       = imem_q[pc_q];
  assign instr_op    = instr[INSTR_W-1:DATA_W];
  assign instr_imm   = instr[DATA_W-1:0];
  assign mem_addr    = instr_imm[DMEM_AW-1:0];
  assign bit_sel     = instr_imm[10:6];
  assign mem_operand = dmem_q[mem_addr];
  assign alu_operand = uses_mem_operand(instr_op) ? mem_operand : instr_imm;

  alu_acc u_alu (
    .opcode   (instr_op),
    .acc      (acc_q),
    .operand  (alu_operand),
    .acc_next (alu_result)
  );

  always_comb begin
    pc_d       = pc_q;
    acc_d      = acc_q;
    op_d       = op_q;
    imem_we    = 1'b0;
    dmem_we    = 1'b0;
    dmem_wdata = mem_operand;
    if (bus.wr) begin
      imem_we = 1'b1;
      pc_d    = '0;
    end else begin
      acc_d = alu_result;
      op_d  = instr_op;
      // HALT re-fetches itself forever, so holding PC is enough to stop the core.
      pc_d  = (instr_op == OP_HALT) ? pc_q : pc_q + 1'b1;
      case (instr_op)
        OP_STORE: begin
          dmem_we    = 1'b1;
          dmem_wdata = acc_q;
        end
        OP_BITSET: begin
          dmem_we    = 1'b1;
          dmem_wdata = mem_operand | (32'd1 << bit_sel);
        end
        OP_BITCLR: begin
          dmem_we    = 1'b1;
          dmem_wdata = mem_operand & ~(32'd1 << bit_sel);
        end
        default: dmem_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      acc_q <= '0;
      op_q  <= '0;
      for (int i = 0; i < IMEM_DEPTH; i++) imem_q[i] <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      acc_q <= acc_d;
      op_q  <= op_d;
      if (imem_we) imem_q[bus.address] <= bus.data_in;
      if (dmem_we) dmem_q[mem_addr] <= dmem_wdata;
    end
  end

  assign bus.data_out      = acc_q;
  assign bus.rc_debug      = acc_q;
  assign bus.pc_debug      = pc_q;
  assign bus.op_code_debug = op_q;

endmodule

// File: tb/tb_procesador_harvard.sv
// Bench for procesador_harvard: opcode table, directed multi-cycle sequences,
// and random programs checked cycle by cycle against an instruction-level model.
module tb_procesador_harvard;
  import procesador_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  procesador_harvard_if bus ();

  procesador_harvard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Instruction-level reference state
  logic [36:0] m_imem [128];
  logic [31:0] m_dmem [64];
  logic [31:0] m_acc;
  int          m_pc;
  logic [4:0]  m_op;

  function automatic logic [36:0] ins(input logic [4:0] op, input logic [31:0] imm);
    return {op, imm};
  endfunction

  function automatic void model_tick();
    logic [36:0] w;
    logic [4:0] op;
    logic [31:0] imm;
    longint unsigned a, b, r, sh;
    longint unsigned wrap;
    wrap = 64'h1_0000_0000;
    if (reset) begin
      for (int i = 0; i < 128; i++) m_imem[i] = '0;
      for (int i = 0; i < 64; i++) m_dmem[i] = '0;
      m_acc = 0; m_pc = 0; m_op = 0;
    end else if (bus.wr) begin
      m_imem[bus.address] = bus.data_in;
      m_pc = 0;
    end else begin
      w   = m_imem[m_pc];
      op  = w[36:32];
      imm = w[31:0];
      a   = longint'(m_acc);
      b   = (op >= 16 && op <= 24) ? longint'(m_dmem[imm[5:0]]) : longint'(imm);
      sh  = longint'(imm[5:0]);
      r   = a;
      case (int'(op))
        1, 16:  r = b;
        2:      r = (sh >= 32) ? 0 : (a * (64'd1 << sh)) % wrap;
        3:      r = (sh >= 32) ? 0 : a / (64'd1 << sh);
        4, 18:  r = (a + b) % wrap;
        5, 19:  r = (a + wrap - b) % wrap;
        6, 20:  r = (a * b) % wrap;
        7, 21:  r = (b == 0) ? wrap - 1 : a / b;
        8, 22:  r = a & b;
        9, 23:  r = a | b;
        10, 24: r = a ^ b;
        11:     r = (a + 1) % wrap;
        12:     r = (a + wrap - 1) % wrap;
        13:     r = (wrap - 1) - a;
        14:     m_dmem[imm[5:0]][imm[10:6]] = 1'b1;
        15:     m_dmem[imm[5:0]][imm[10:6]] = 1'b0;
        17:     m_dmem[imm[5:0]] = m_acc;
        default: r = a;
      endcase
      m_acc = r[31:0];
      m_op  = op;
      if (op != 5'd31) m_pc = (m_pc + 1) % 128;
    end
  endfunction

  task automatic tick();
    model_tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    bus.wr = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_word(input int addr, input logic [36:0] w);
    bus.wr      = 1'b1;
    bus.address = 7'(addr);
    bus.data_in = w;
    tick();
  endtask

  task automatic run(input int n);
    bus.wr = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_state(input string tag, input logic [31:0] acc, input int pc, input logic [4:0] op);
    check({tag, ".acc"}, bus.data_out, acc);
    check({tag, ".pc"}, 32'(bus.pc_debug), 32'(pc));
    check({tag, ".op"}, 32'(bus.op_code_debug), 32'(op));
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] m;
    logic [31:0] a;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  initial begin
    bus.wr = 1'b0;
    bus.address = '0;
    bus.data_in = '0;

    tbl[0]  = '{5'd1,  32'h0, 32'h0,          32'hFF,         32'hFF};
    tbl[1]  = '{5'd2,  32'h0, 32'h1,          32'd31,         32'h8000_0000};
    tbl[2]  = '{5'd2,  32'h0, 32'hFFFF_FFFF,  32'd32,         32'h0};
    tbl[3]  = '{5'd3,  32'h0, 32'h8000_0000,  32'd31,         32'h1};
    tbl[4]  = '{5'd3,  32'h0, 32'hFFFF_FFFF,  32'd63,         32'h0};
    tbl[5]  = '{5'd4,  32'h0, 32'hFFFF_FFFF,  32'd2,          32'h1};
    tbl[6]  = '{5'd5,  32'h0, 32'h0,          32'd1,          32'hFFFF_FFFF};
    tbl[7]  = '{5'd6,  32'h0, 32'h0001_0000,  32'h0001_0001,  32'h0001_0000};
    tbl[8]  = '{5'd7,  32'h0, 32'd100,        32'd7,          32'd14};
    tbl[9]  = '{5'd7,  32'h0, 32'd9,          32'd0,          32'hFFFF_FFFF};
    tbl[10] = '{5'd8,  32'h0, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000};
    tbl[11] = '{5'd9,  32'h0, 32'hF0F0_F0F0,  32'h0F,         32'hF0F0_F0FF};
    tbl[12] = '{5'd10, 32'h0, 32'hFFFF_0000,  32'hFF00_FF00,  32'h00FF_FF00};
    tbl[13] = '{5'd11, 32'h0, 32'hFFFF_FFFF,  32'h0,          32'h0};
    tbl[14] = '{5'd12, 32'h0, 32'h0,          32'h0,          32'hFFFF_FFFF};
    tbl[15] = '{5'd13, 32'h0, 32'h0F0F_0F0F,  32'h0,          32'hF0F0_F0F0};
    tbl[16] = '{5'd16, 32'd7, 32'd5,          32'd5,          32'd7};
    tbl[17] = '{5'd18, 32'd7, 32'd5,          32'd5,          32'd12};
    tbl[18] = '{5'd19, 32'd7, 32'd5,          32'd5,          32'hFFFF_FFFE};
    tbl[19] = '{5'd20, 32'd7, 32'd5,          32'd5,          32'd35};
    tbl[20] = '{5'd21, 32'd7, 32'd35,         32'd5,          32'd5};
    tbl[21] = '{5'd21, 32'd0, 32'd3,          32'd5,          32'hFFFF_FFFF};
    tbl[22] = '{5'd22, 32'hC, 32'hA,          32'd5,          32'h8};
    tbl[23] = '{5'd23, 32'hC, 32'hA,          32'd5,          32'hE};
    tbl[24] = '{5'd24, 32'hC, 32'hA,          32'd5,          32'h6};
    tbl[25] = '{5'd25, 32'h0, 32'd5,          32'd0,          32'd5};
    tbl[26] = '{5'd17, 32'h0, 32'd5,          32'd6,          32'd5};
    tbl[27] = '{5'd14, 32'h0, 32'd5,          32'((3 << 6) | 5), 32'd5};

    // Reset state
    do_reset();
    check_state("reset", 32'h0, 0, 5'd0);
    check("reset.rc", bus.rc_debug, 32'h0);

    // Opcode table: MOVI m; STORE 5; MOVI a; <op imm>
    for (int v = 0; v < NV; v++) begin
      do_reset();
      load_word(0, ins(5'd1, tbl[v].m));
      load_word(1, ins(5'd17, 32'd5));
      load_word(2, ins(5'd1, tbl[v].a));
      load_word(3, ins(tbl[v].op, tbl[v].imm));
      run(4);
      $display("vector %0d op=%0d a=0x%08h imm=0x%08h -> acc=0x%08h", v, tbl[v].op, tbl[v].a, tbl[v].imm, bus.data_out);
      check_state($sformatf("tbl%0d", v), tbl[v].exp, 4, tbl[v].op);
    end

    // First-edge MOVI, then NOT, then HALT holding for 5 cycles
    do_reset();
    load_word(0, ins(5'd1, 32'h0F0F_0F0F));
    load_word(1, ins(5'd13, 32'h0));
    load_word(2, ins(5'd31, 32'h0));
    run(1);
    check_state("movi1", 32'h0F0F_0F0F, 1, 5'd1);
    run(2);
    for (int c = 0; c < 5; c++) begin
      run(1);
      check_state($sformatf("halt%0d", c), 32'hF0F0_F0F0, 2, 5'd31);
    end

    // Shift chain
    do_reset();
    load_word(0, ins(5'd1, 32'd1));
    for (int i = 1; i <= 31; i++) load_word(i, ins(5'd2, 32'd1));
    load_word(32, ins(5'd3, 32'd31));
    load_word(33, ins(5'd31, 32'd0));
    run(32);
    check_state("shl31", 32'h8000_0000, 32, 5'd2);
    run(1);
    check_state("shr31", 32'h1, 33, 5'd3);
    run(3);
    check_state("shlhalt", 32'h1, 33, 5'd31);

    // Memory arithmetic chain
    do_reset();
    load_word(0, ins(5'd1, 32'd7));
    load_word(1, ins(5'd17, 32'd20));
    load_word(2, ins(5'd1, 32'd5));
    load_word(3, ins(5'd20, 32'd20));
    load_word(4, ins(5'd19, 32'd20));
    load_word(5, ins(5'd21, 32'd20));
    load_word(6, ins(5'd16, 32'd20));
    run(4); check("mul20", bus.data_out, 32'd35);
    run(1); check("sub20", bus.data_out, 32'd28);
    run(1); check("div20", bus.data_out, 32'd4);
    run(1); check("load20", bus.data_out, 32'd7);

    // Bit ops on cleared dmem
    do_reset();
    load_word(0, ins(5'd14, 32'((3 << 6) | 20)));
    load_word(1, ins(5'd15, 32'((0 << 6) | 20)));
    load_word(2, ins(5'd16, 32'd20));
    load_word(3, ins(5'd14, 32'((3 << 6) | 20)));
    load_word(4, ins(5'd16, 32'd20));
    run(1); check("bitset.acc", bus.data_out, 32'h0);
    run(2); check("bitops.load", bus.data_out, 32'h8);
    run(2); check("bitset2.load", bus.data_out, 32'h8);

    // Reset mid-run clears registers and both memories
    do_reset();
    load_word(0, ins(5'd1, 32'h1234));
    load_word(1, ins(5'd17, 32'd20));
    load_word(2, ins(5'd11, 32'd0));
    run(3);
    check("prerst", bus.data_out, 32'h1235);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_state("midrst", 32'h0, 0, 5'd0);
    run(3);
    check_state("rstimem", 32'h0, 3, 5'd0);
    load_word(0, ins(5'd16, 32'd20));
    run(1);
    check("rstdmem", bus.data_out, 32'h0);

    // wr mid-run parks PC and holds ACC
    do_reset();
    load_word(0, ins(5'd1, 32'h55));
    load_word(1, ins(5'd11, 32'd0));
    load_word(2, ins(5'd11, 32'd0));
    run(2);
    load_word(9, ins(5'd1, 32'hAA));
    check_state("midwr", 32'h56, 0, 5'd11);
    run(1);
    check_state("restart", 32'h55, 1, 5'd1);

    // Random programs against the reference model
    for (int it = 0; it < 15; it++) begin
      do_reset();
      for (int i = 0; i < 40; i++) begin
        logic [4:0] op;
        logic [31:0] imm;
        op = 5'($urandom_range(0, 31));
        if (op == 5'd31 && $urandom_range(0, 3) != 0) op = 5'd11;
        imm = $urandom;
        if ($urandom_range(0, 1) == 1) imm = 32'($urandom_range(0, 40)) | (imm & 32'h7C0);
        load_word(i, ins(op, imm));
      end
      bus.wr = 1'b0;
      for (int c = 0; c < 70; c++) begin
        if ($urandom_range(0, 40) == 0) begin
          bus.wr      = 1'b1;
          bus.address = 7'($urandom_range(0, 127));
          bus.data_in = {5'($urandom_range(0, 31)), 32'($urandom)};
          tick();
          bus.wr = 1'b0;
        end else begin
          tick();
        end
        check_state($sformatf("rnd%0d.%0d", it, c), m_acc, m_pc, m_op);
      end
      $display("random program %0d done: acc=0x%08h pc=%0d", it, bus.data_out, bus.pc_debug);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
